weight_loader: RTL and testbench



---
 rtl/weight_loader_pkg.sv | 20 ++
 rtl/weight_loader_if.sv | 11 +
 rtl/weight_loader.sv | 142 ++++++++++++++
 tb/tb_weight_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// rtl/weight_loader_pkg.sv - shared state encoding and header field positions for weight_loader
package weight_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SKIP = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } wl_state_t;

    localparam int LAYER_MSB  = 31;
    localparam int LAYER_LSB  = 24;
    localparam int NEURON_MSB = 23;
    localparam int NEURON_LSB = 16;
    localparam int COUNT_MSB  = 15;
    localparam int COUNT_LSB  = 0;
    localparam int COUNT_W    = COUNT_MSB - COUNT_LSB + 1;

endpackage

// File: rtl/weight_loader_if.sv
// rtl/weight_loader_if.sv - configuration word stream (valid/ready, 32-bit data)
interface weight_loader_if;

    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);

endinterface

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - filters a header+weights stream for one layer and drives the neuron weight-memory write port
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int layerNo      = 0,
    parameter int numNeuron    = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int neuronWidth  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_loader_if.slave          cfg,
    output logic                    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic [neuronWidth-1:0]  wneuron,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int AW1 = addressWidth + 1;

    wl_state_t              state, state_n;
    logic [AW1-1:0]         addr, addr_n;
    logic [COUNT_W-1:0]     count, count_n;
    logic [COUNT_W-1:0]     remaining, remaining_n;
    logic                   rejected, rejected_n;
    logic [neuronWidth-1:0] neuron, neuron_n;
    logic                   ready_q;
    logic                   xfer;

    logic [7:0]             hdr_layer;
    logic [7:0]             hdr_neuron;
    logic [COUNT_W-1:0]     hdr_count;
    logic                   hdr_ok;

    assign hdr_layer  = cfg.cfg_data[LAYER_MSB:LAYER_LSB];
    assign hdr_neuron = cfg.cfg_data[NEURON_MSB:NEURON_LSB];
    assign hdr_count  = cfg.cfg_data[COUNT_MSB:COUNT_LSB];
    assign hdr_ok     = (32'(hdr_neuron) < 32'(numNeuron)) && (hdr_count != '0)
                        && (32'(hdr_count) <= 32'(numWeight));

    assign xfer          = cfg.cfg_valid && ready_q;
    assign cfg.cfg_ready = ready_q;
    assign busy          = (state == LOAD) || (state == SKIP);
    assign done          = (state == DONE);
    assign err           = (state == ERR);

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        count_n     = count;
        remaining_n = remaining;
        rejected_n  = rejected;
        neuron_n    = neuron;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (hdr_layer == 8'(layerNo)) begin
                        if (hdr_ok) begin
                            state_n  = LOAD;
                            neuron_n = hdr_neuron[neuronWidth-1:0];
                            count_n  = hdr_count;
                            addr_n   = '0;
                        end else if (hdr_count == '0) begin
                            state_n = ERR;
                        end else begin
                            state_n     = SKIP;
                            remaining_n = hdr_count;
                            rejected_n  = 1'b1;
                        end
                    end else if (hdr_count != '0) begin
                        // Foreign blocks are drained silently so the stream stays aligned.
                        state_n     = SKIP;
                        remaining_n = hdr_count;
                        rejected_n  = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    addr_n = addr + 1'b1;
                    if (COUNT_W'(addr) == count - 1'b1) begin
                        state_n = DONE;
                    end
                end
            end
            SKIP: begin
                if (xfer) begin
                    remaining_n = remaining - 1'b1;
                    if (remaining == COUNT_W'(1)) begin
                        state_n = rejected ? ERR : IDLE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            remaining <= '0;
            rejected  <= 1'b0;
            neuron    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            count     <= count_n;
            remaining <= remaining_n;
            rejected  <= rejected_n;
            neuron    <= neuron_n;
            // Registered so ready is low during reset yet always equals "state accepts words".
            ready_q   <= (state_n == IDLE) || (state_n == LOAD) || (state_n == SKIP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen     <= 1'b0;
            wadd    <= '0;
            win     <= '0;
            wneuron <= '0;
        end else begin
            wen <= (state == LOAD) && xfer;
            if ((state == LOAD) && xfer) begin
                wadd    <= addr[addressWidth-1:0];
                win     <= cfg.cfg_data[dataWidth-1:0];
                wneuron <= neuron;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed self-checking bench for weight_loader at layerNo=1
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen;
    logic [9:0]  wadd;
    logic [15:0] win;
    logic [4:0]  wneuron;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    int n_wen = 0, n_done = 0, n_err = 0, n_busy = 0, n_xfer = 0;
    int b_wen, b_done, b_err, b_busy, b_xfer;

    weight_loader_if cfg ();

    weight_loader #(
        .layerNo(1), .numNeuron(30), .numWeight(784),
        .addressWidth(10), .dataWidth(16), .neuronWidth(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg.slave),
        .wen(wen), .wadd(wadd), .win(win), .wneuron(wneuron),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) n_wen++;
        if (done) n_done++;
        if (err) n_err++;
        if (busy) n_busy++;
        if (cfg.cfg_valid && cfg.cfg_ready) n_xfer++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_data  = w;
        while (!cfg.cfg_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
        step();
    endtask

    task automatic idle(input int cycles);
        cfg.cfg_valid = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic snap();
        b_wen = n_wen; b_done = n_done; b_err = n_err; b_busy = n_busy; b_xfer = n_xfer;
    endtask

    logic [4:0] pat;
    int idx;
    int k;
    int v;

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = '0;
        #12;
        chk("rst_ready", cfg.cfg_ready, 0);
        chk("rst_outs", {wen, busy, done, err, wneuron}, 0);
        chk("rst_wadd", wadd, 0);
        chk("rst_win", win, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", cfg.cfg_ready, 1);

        // Basic block: neuron 3, four weights, valid held.
        snap();
        send(32'h0103_0004);
        chk("t1_busy_hdr", busy, 1);
        chk("t1_wen_hdr", wen, 0);
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_0011 + 32'(i));
            chk("t1_wen", wen, 1);
            chk("t1_wadd", wadd, 32'(i));
            chk("t1_win", win, 32'h11 + 32'(i));
            chk("t1_wneuron", wneuron, 3);
        end
        chk("t1_done", done, 1);
        chk("t1_ready_done", cfg.cfg_ready, 0);
        chk("t1_busy_done", busy, 0);
        idle(1);
        chk("t1_done_clr", done, 0);
        chk("t1_wen_clr", wen, 0);
        idle(2);
        chk("t1_busy_cnt", n_busy - b_busy, 4);
        chk("t1_done_cnt", n_done - b_done, 1);

        // Foreign layer block is drained without writes.
        snap();
        send(32'h0200_0003);
        for (int i = 0; i < 3; i++) send(32'h0000_0100 + 32'(i));
        idle(3);
        chk("t2_xfer", n_xfer - b_xfer, 4);
        chk("t2_wen", n_wen - b_wen, 0);
        chk("t2_done", n_done - b_done, 0);
        chk("t2_err", n_err - b_err, 0);
        chk("t2_busy", n_busy - b_busy, 3);

        // Neuron out of range: skipped, single err.
        snap();
        send(32'h011E_0002);
        send(32'h0000_0AAA);
        send(32'h0000_0BBB);
        idle(3);
        chk("t3_xfer", n_xfer - b_xfer, 3);
        chk("t3_wen", n_wen - b_wen, 0);
        chk("t3_err", n_err - b_err, 1);
        // Recovery block; upper data bits must be dropped.
        send(32'h0105_0002);
        send(32'hABCD_1234);
        chk("t3_wen_ok", wen, 1);
        chk("t3_win_trunc", win, 32'h1234);
        chk("t3_wneuron", wneuron, 5);
        chk("t3_wadd0", wadd, 0);
        send(32'h0000_5678);
        chk("t3_wadd1", wadd, 1);
        chk("t3_done", done, 1);
        idle(2);

        // Zero count: immediate err, nothing else consumed.
        snap();
        send(32'h0100_0000);
        cfg.cfg_valid = 1'b0;
        chk("t4_err_now", err, 1);
        chk("t4_ready_err", cfg.cfg_ready, 0);
        step();
        chk("t4_err_clr", err, 0);
        idle(2);
        chk("t4_xfer", n_xfer - b_xfer, 1);

        // Count 785 > 784: all words skipped then err.
        snap();
        send(32'h0100_0311);
        for (int i = 0; i < 785; i++) send(32'(i));
        idle(3);
        chk("t5_xfer", n_xfer - b_xfer, 786);
        chk("t5_wen", n_wen - b_wen, 0);
        chk("t5_err", n_err - b_err, 1);
        chk("t5_busy", n_busy - b_busy, 785);

        // Gapped stream 1,0,1,1,0: addresses must stay contiguous.
        snap();
        pat = 5'b01101;
        send(32'h0102_0005);
        idx = 0;
        k = 0;
        while (idx < 5 && k < 40) begin
            v = int'(pat[k % 5]);
            cfg.cfg_valid = pat[k % 5];
            cfg.cfg_data  = 32'h0000_0200 + 32'(idx);
            step();
            chk("t6_wen", wen, 32'(v));
            if (v == 1) begin
                chk("t6_wadd", wadd, 32'(idx));
                chk("t6_win", win, 32'h200 + 32'(idx));
            end
            idx += v;
            k++;
        end
        chk("t6_done", done, 1);
        idle(2);
        chk("t6_wen_cnt", n_wen - b_wen, 5);

        // Reset in the middle of a block.
        send(32'h0103_0004);
        send(32'h0000_0021);
        send(32'h0000_0022);
        chk("t7_wen_pre", wen, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_outs", {wen, busy, done, err, wneuron}, 0);
        chk("t7_rst_wadd", wadd, 0);
        chk("t7_rst_win", win, 0);
        chk("t7_rst_ready", cfg.cfg_ready, 0);
        cfg.cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(32'h0103_0004);
        send(32'h0000_0077);
        chk("t7_wadd_restart", wadd, 0);
        chk("t7_win", win, 32'h77);
        chk("t7_wneuron", wneuron, 3);
        for (int i = 0; i < 3; i++) send(32'h0000_0078 + 32'(i));
        chk("t7_done", done, 1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
